// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between the fetch and data ports; optional ack timeout via MEM_ARB_TIMEOUT_EN.
// Latency: grant one edge after the request, port ack one edge after mem_ack_i; one RESP cycle before the next grant.
// Backpressure: a grant holds mem_req_o until mem_ack_i, and stall_o freezes the pipeline while any request is unacked.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IF = 2'd1,
        GRANT_D  = 2'd2,
        RESP     = 2'd3
    } state_t;

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

    state_t              state_q, state_d;
    logic [STREAK_W-1:0] d_streak_q, d_streak_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                if_ack_q, if_ack_d;
    logic                d_ack_q, d_ack_d;

    logic sel_data;
    logic sel_fetch;
    logic in_grant;
    logic timeout_hit;

    // Data wins ties until it has starved a waiting fetch MAX_D_STREAK times in a row.
    assign sel_data  = d_req_i && (!if_req_i || (d_streak_q < STREAK_W'(MAX_D_STREAK)));
    assign sel_fetch = if_req_i && !sel_data;
    assign in_grant  = (state_q == GRANT_IF) || (state_q == GRANT_D);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT + 1);
    localparam int CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;

    assign timeout_hit = in_grant && (wait_cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        wait_cnt_d = '0;
        err_d      = err_q;
        if (in_grant) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
        if (timeout_hit && !mem_ack_i) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        d_streak_d  = d_streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sel_data) begin
                    state_d     = GRANT_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we_i;
                    mem_addr_d  = {d_addr_i[ADDR_W-1:2], 2'b00};
                    mem_wdata_d = d_wdata_i;
                    if (!if_req_i) begin
                        d_streak_d = '0;
                    end else if (d_streak_q != STREAK_W'(MAX_D_STREAK)) begin
                        d_streak_d = d_streak_q + STREAK_W'(1);
                    end
                end else if (sel_fetch) begin
                    state_d    = GRANT_IF;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {if_addr_i[ADDR_W-1:2], 2'b00};
                    d_streak_d = '0;
                end
            end
            GRANT_IF, GRANT_D: begin
                // A real ack wins over a timeout landing on the same cycle.
                if (mem_ack_i || timeout_hit) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (state_q == GRANT_IF) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_ack_i ? mem_rdata_i : '0;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = mem_ack_i ? mem_rdata_i : '0;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            d_streak_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_streak_q  <= d_streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign if_ack_o    = if_ack_q;
    assign d_ack_o     = d_ack_q;

    assign stall_o = (if_req_i && !if_ack_q) || (d_req_i && !d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-programmable memory model.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam logic [31:0] PAT = 32'h5A5A_0000;

    logic              clk_i;
    logic              rst_i;
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_ack_o;
    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic [DATA_W-1:0] d_rdata_o;
    logic              d_ack_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ack_i;
    logic              stall_o;
    logic              err_o;

    int checks = 0;
    int errors = 0;

    // memory model controls
    bit          mem_auto  = 1'b1;
    bit          force_ack = 1'b0;
    bit          use_fixed = 1'b0;
    logic [31:0] fixed_val = 32'h0;
    int          mem_lat   = 0;
    int          lat_cnt   = 0;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_D_STREAK(4), .TIMEOUT(10)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .stall_o(stall_o), .err_o(err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Memory: acks mem_lat negedges after seeing the request, data = address ^ PAT unless fixed.
    initial begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            if (!mem_auto) begin
                mem_ack_i = force_ack;
                lat_cnt   = 0;
            end else if (mem_req_o && !mem_ack_i) begin
                if (lat_cnt >= mem_lat) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = use_fixed ? fixed_val : (mem_addr_o ^ PAT);
                    lat_cnt     = 0;
                end else begin
                    lat_cnt = lat_cnt + 1;
                end
            end else begin
                mem_ack_i = 1'b0;
                lat_cnt   = 0;
            end
        end
    end

    task automatic test_reset();
        rst_i     = 1'b0;
        if_req_i  = 1'b0;
        if_addr_i = '0;
        d_req_i   = 1'b0;
        d_we_i    = 1'b0;
        d_addr_i  = '0;
        d_wdata_i = '0;
        #2;
        checks++;
        if ({mem_req_o, mem_we_o, if_ack_o, d_ack_o, err_o, stall_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, want 000000",
                     {mem_req_o, mem_we_o, if_ack_o, d_ack_o, err_o, stall_o});
        end
        checks++;
        if ({mem_addr_o, mem_wdata_o, if_rdata_o, d_rdata_o} !== 128'b0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h, want all 0",
                     mem_addr_o, mem_wdata_o, if_rdata_o, d_rdata_o);
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_fetch_only();
        int  ack_cyc = -1;
        bit  stall_bad = 1'b0;
        logic [31:0] seen_addr = 32'hFFFF_FFFF;
        logic        seen_we = 1'b1;
        mem_lat   = 2;
        use_fixed = 1'b1;
        fixed_val = 32'h00A0_0093;
        if_addr_i = 32'h0000_0008;
        if_req_i  = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL fetch_stall_start: got %b, want 1", stall_o);
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk_i);
            if (mem_req_o) begin
                seen_addr = mem_addr_o;
                seen_we   = mem_we_o;
            end
            if (if_ack_o) begin
                ack_cyc = c;
                checks++;
                if (stall_o !== 1'b0) begin
                    errors++;
                    $display("FAIL fetch_stall_ack: got %b, want 0", stall_o);
                end
                if_req_i = 1'b0;
                break;
            end else if (stall_o !== 1'b1) begin
                stall_bad = 1'b1;
            end
        end
        checks++;
        if (ack_cyc !== 4) begin
            errors++;
            $display("FAIL fetch_latency: got %0d, want 4", ack_cyc);
        end
        checks++;
        if (stall_bad) begin
            errors++;
            $display("FAIL fetch_stall_hold: got 0 before ack, want 1");
        end
        checks++;
        if ({seen_addr, seen_we} !== {32'h0000_0008, 1'b0}) begin
            errors++;
            $display("FAIL fetch_mem_addr_we: got %h/%b, want 00000008/0", seen_addr, seen_we);
        end
        checks++;
        if (if_rdata_o !== 32'h00A0_0093) begin
            errors++;
            $display("FAIL fetch_rdata: got %h, want 00a00093", if_rdata_o);
        end
        @(negedge clk_i);
        checks++;
        if (if_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL fetch_ack_pulse: got %b, want 0", if_ack_o);
        end
        use_fixed = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_simultaneous();
        int d_cyc = -1;
        int i_cyc = -1;
        mem_lat   = 0;
        d_addr_i  = 32'h0000_0104;
        d_we_i    = 1'b0;
        if_addr_i = 32'h0000_0010;
        d_req_i   = 1'b1;
        if_req_i  = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk_i);
            if (d_ack_o) begin
                d_cyc   = c;
                d_req_i = 1'b0;
            end
            if (if_ack_o) begin
                i_cyc    = c;
                if_req_i = 1'b0;
                break;
            end
        end
        checks++;
        if (d_cyc !== 2) begin
            errors++;
            $display("FAIL sim_data_first: got cycle %0d, want 2", d_cyc);
        end
        checks++;
        if (i_cyc !== 5) begin
            errors++;
            $display("FAIL sim_fetch_after: got cycle %0d, want 5", i_cyc);
        end
        checks++;
        if ({d_rdata_o, if_rdata_o} !== {32'h5A5A_0104, 32'h5A5A_0010}) begin
            errors++;
            $display("FAIL sim_rdata: got %h/%h, want 5a5a0104/5a5a0010", d_rdata_o, if_rdata_o);
        end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_store();
        bit saw_req = 1'b0;
        bit unstable = 1'b0;
        bit acked = 1'b0;
        mem_lat   = 3;
        d_addr_i  = 32'h0000_010B;
        d_wdata_i = 32'hDEAD_BEEF;
        d_we_i    = 1'b1;
        d_req_i   = 1'b1;
        @(negedge clk_i);
        d_we_i    = 1'b0;   // only sampled at grant
        d_wdata_i = 32'h1234_5678;
        for (int c = 1; c <= 20; c++) begin
            if (mem_req_o) begin
                saw_req = 1'b1;
                if ({mem_addr_o, mem_we_o, mem_wdata_o} !== {32'h0000_0108, 1'b1, 32'hDEAD_BEEF})
                    unstable = 1'b1;
            end
            if (d_ack_o) begin
                acked   = 1'b1;
                d_req_i = 1'b0;
                break;
            end
            @(negedge clk_i);
        end
        checks++;
        if (!(saw_req && acked)) begin
            errors++;
            $display("FAIL store_handshake: got req=%b ack=%b, want 1/1", saw_req, acked);
        end
        checks++;
        if (unstable) begin
            errors++;
            $display("FAIL store_mem_fields: got changing/incorrect fields, want 00000108/1/deadbeef");
        end
        checks++;
        if (d_rdata_o !== 32'h5A5A_0108) begin
            errors++;
            $display("FAIL store_rdata: got %h, want 5a5a0108", d_rdata_o);
        end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_streak();
        bit prev = 1'b0;
        int gcount = 0;
        bit kind [10];
        mem_lat   = 0;
        if_addr_i = 32'h0000_0040;
        d_addr_i  = 32'h0000_0200;
        d_we_i    = 1'b0;
        if_req_i  = 1'b1;
        d_req_i   = 1'b1;
        for (int c = 1; c <= 80 && gcount < 10; c++) begin
            @(negedge clk_i);
            if (mem_req_o && !prev) begin
                kind[gcount] = (mem_addr_o == 32'h0000_0040);
                gcount++;
            end
            prev = mem_req_o;
        end
        if_req_i = 1'b0;
        d_req_i  = 1'b0;
        checks++;
        if (gcount !== 10) begin
            errors++;
            $display("FAIL streak_grants: got %0d, want 10", gcount);
        end
        for (int i = 0; i < gcount; i++) begin
            checks++;
            if (kind[i] !== ((i == 4) || (i == 9))) begin
                errors++;
                $display("FAIL streak_order[%0d]: got fetch=%b, want %b", i, kind[i], (i == 4) || (i == 9));
            end
        end
        repeat (5) @(negedge clk_i);
    endtask

    task automatic test_ack_in_idle();
        bit spurious = 1'b0;
        mem_auto  = 1'b0;
        force_ack = 1'b1;
        @(negedge clk_i);
        force_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            if (if_ack_o || d_ack_o || mem_req_o) spurious = 1'b1;
        end
        checks++;
        if (spurious) begin
            errors++;
            $display("FAIL idle_ack_ignored: got ack/req activity, want none");
        end
    endtask

    task automatic test_reset_mid();
        bit granted = 1'b0;
        bit spurious = 1'b0;
        int i_cyc = -1;
        mem_auto = 1'b0;
        d_addr_i = 32'h0000_0300;
        d_we_i   = 1'b0;
        d_req_i  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            if (mem_req_o) begin
                granted = 1'b1;
                break;
            end
        end
        checks++;
        if (!granted) begin
            errors++;
            $display("FAIL rst_mid_grant: got mem_req_o=0, want 1");
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checks++;
        if ({mem_req_o, d_ack_o} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_async: got req=%b ack=%b, want 0/0", mem_req_o, d_ack_o);
        end
        @(negedge clk_i);
        rst_i   = 1'b1;
        d_req_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            if (d_ack_o || mem_req_o) spurious = 1'b1;
        end
        checks++;
        if (spurious) begin
            errors++;
            $display("FAIL rst_mid_no_ack: got ack/req after reset, want none");
        end
        mem_auto  = 1'b1;
        mem_lat   = 0;
        if_addr_i = 32'h0000_0022;
        if_req_i  = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_i);
            if (if_ack_o) begin
                i_cyc    = c;
                if_req_i = 1'b0;
                break;
            end
        end
        checks++;
        if ({i_cyc, if_rdata_o} !== {32'd2, 32'h5A5A_0020}) begin
            errors++;
            $display("FAIL rst_mid_recover: got cycle %0d rdata %h, want 2/5a5a0020", i_cyc, if_rdata_o);
        end
        repeat (2) @(negedge clk_i);
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int g_cyc = -1;
        int a_cyc = -1;
        mem_auto = 1'b0;
        d_addr_i = 32'h0000_0400;
        d_we_i   = 1'b0;
        d_req_i  = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_i);
            if (mem_req_o && g_cyc < 0) g_cyc = c;
            if (d_ack_o) begin
                a_cyc   = c;
                d_req_i = 1'b0;
                break;
            end
        end
        checks++;
        if (a_cyc - g_cyc !== 10 || g_cyc < 0) begin
            errors++;
            $display("FAIL timeout_delay: got %0d cycles, want 10", a_cyc - g_cyc);
        end
        checks++;
        if ({d_rdata_o, err_o, mem_req_o} !== {32'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL timeout_result: got rdata %h err %b req %b, want 0/1/0", d_rdata_o, err_o, mem_req_o);
        end
        repeat (4) @(negedge clk_i);
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got %b, want 1", err_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_store();
        test_streak();
        test_ack_in_idle();
        test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`else
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_tied_low: got %b, want 0", err_o);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency unified memory between the pipeline's instruction-fetch port and its data (MEM-stage) port.
- Sequences each access with a request/acknowledge handshake.
- Drives the pipeline-wide stall so that all pipeline buffers freeze while any access is outstanding.
- Sits between the CPU top level (fetch address, MEM-stage address, store data, write enable) and the memory model.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MAX_D_STREAK, 4, maximum consecutive data grants while a fetch request waits; then fetch is granted once.
- TIMEOUT, 255, cycles to wait for mem_ack_i before abort (used only with the optional feature).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- if_req_i  in  1  fetch request, level, held until if_ack_o.
- if_addr_i  in  ADDR_W  fetch byte address.
- if_rdata_o  out  DATA_W  fetched instruction, valid with if_ack_o.
- if_ack_o  out  1  one-cycle fetch completion pulse.
- d_req_i  in  1  data request, level, held until d_ack_o.
- d_we_i  in  1  1 = store, 0 = load.
- d_addr_i  in  ADDR_W  data byte address.
- d_wdata_i  in  DATA_W  store data.
- d_rdata_o  out  DATA_W  load data, valid with d_ack_o.
- d_ack_o  out  1  one-cycle data completion pulse.
- mem_req_o  out  1  memory request, held until mem_ack_i.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2],2'b00}.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i.
- mem_ack_i  in  1  memory completion, one-cycle pulse.
- stall_o  out  1  pipeline stall.
- err_o  out  1  sticky timeout flag (0 when the optional feature is compiled out).

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE, d_streak=0.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - if_ack_o=0, d_ack_o=0, if_rdata_o=0, d_rdata_o=0, err_o=0.
- States: IDLE, GRANT_IF, GRANT_D, RESP.
- IDLE grant decision, evaluated every cycle:
  - Both requests pending and d_streak<MAX_D_STREAK: grant data.
  - Both pending and d_streak==MAX_D_STREAK: grant fetch.
  - Only one pending: grant that one.
  - None pending: stay in IDLE.
- At grant (registered, next edge):
  - Latch address, we and wdata into the mem_* outputs.
  - mem_req_o=1.
  - Move to GRANT_IF or GRANT_D.
  - Fetch grants force mem_we_o=0.
- d_streak:
  - +1 on a data grant while if_req_i=1, saturating at MAX_D_STREAK.
  - Cleared on any fetch grant, and on a data grant while if_req_i=0.
- GRANT_x:
  - mem_req_o and all mem_* outputs held stable until mem_ack_i=1.
  - On mem_ack_i, next edge: mem_req_o=0, mem_rdata_i captured into the granted port's rdata, the granted ack pulses for exactly 1 cycle, state=RESP.
- RESP:
  - One cycle. Lets the requester drop or advance its request before re-arbitration.
  - Returns to IDLE. No grant is issued in RESP.
- Minimum access latency: request at cycle 0 → grant edge 1 → mem_ack_i at earliest cycle 1 → ack_o at cycle 2. With zero-wait memory, back-to-back throughput is 1 access per 3 cycles.
- rdata outputs hold their last value until the next ack on that port.
- Stores: d_rdata_o is still updated from mem_rdata_i on ack; the requester ignores it.
- stall_o (combinational) = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o).
- mem_ack_i while in IDLE or RESP: ignored, no ack generated.
- A request dropped before its ack: undefined requester behaviour. The arbiter still completes the transaction and issues the ack.
- Reset asserted mid-transaction: immediate return to IDLE, mem_req_o=0. The outstanding memory access is abandoned and no ack is issued.
- d_we_i is sampled only at grant.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit minimum (clog2(TIMEOUT+1)) wait counter runs in GRANT_x and clears at grant.
  - When the count reaches TIMEOUT without mem_ack_i: mem_req_o=0, the granted ack pulses with rdata=0, err_o set (sticky until reset), state=RESP.
- Not defined: no counter, err_o tied to 0, waits indefinitely.

Test Plan:
- Fetch only, if_addr_i=0x00000008, memory acks 2 cycles after mem_req_o rises with rdata 0x00A00093 → mem_addr_o=0x8, mem_we_o=0, if_ack_o 1-cycle pulse, if_rdata_o=0x00A00093, stall_o high from request until the ack cycle.
- Simultaneous d_req_i load 0x104 and if_req_i 0x10, zero-wait memory → data granted first (d_ack_o before if_ack_o), then fetch 3 cycles later.
- Store d_addr_i=0x0000010B, d_wdata_i=0xDEADBEEF → mem_addr_o=0x108, mem_we_o=1, mem_wdata_o=0xDEADBEEF held stable until mem_ack_i, then d_ack_o.
- Fetch held pending with continuous data requests, MAX_D_STREAK=4 → exactly 4 data grants, then 1 fetch grant, then d_streak=0.
- rst_i pulled low while in GRANT_D with mem_req_o=1 → mem_req_o=0 immediately, no d_ack_o, state IDLE, and the next request is serviced normally after release.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT=10, memory never acks → the granted ack fires 10 cycles after grant with rdata 0, err_o=1 and stays 1.
